// File: rtl/timer_sched.sv
// ---------------------------------------------------------------------------
// timer_sched -- four-channel shared up-counter timer with round-robin
// scheduling.
//
// Each channel latches a one-cycle request into 'pending'. While enabled, the
// scheduler picks one pending channel by round-robin and hands it the timer.
// The counter is loaded with that channel's start value. It then counts up on
// prescaled ticks until it wraps from all-ones to zero. At that point the
// owner receives a one-cycle 'done' pulse.
//
// Handshake: req/abort are single-cycle strobes sampled on the rising clock
// edge; there is no back-pressure. A request is remembered in 'pending' until
// its channel is served (done) or cancelled (abort). 'done' is a one-cycle
// strobe and is never retried.
//
// Ports:
//   clk            in   single clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   en             in   scheduler enable; low forces IDLE and suppresses done
//   prescaler_conf in   [2:0]  tick every 2^k clk cycles while running
//   req            in   [3:0]  per-channel request strobe
//   abort          in   [3:0]  per-channel cancel strobe
//   load_flat      in   [4*CNT_W-1:0] per-channel start value, channel i at
//                       bits [CNT_W*i +: CNT_W]
//   grant          out  [3:0]  one-hot timer owner, 0 when no owner
//   done           out  [3:0]  one-cycle rollover strobe to the owner
//   busy           out  high whenever the FSM is not IDLE
//   pending        out  [3:0]  outstanding requests
//   cur_count      out  [CNT_W-1:0] counter value
// ---------------------------------------------------------------------------
module timer_sched #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         prescaler_conf,
  input  logic [3:0]         req,
  input  logic [3:0]         abort,
  input  logic [4*CNT_W-1:0] load_flat,
  output logic [3:0]         grant,
  output logic [3:0]         done,
  output logic               busy,
  output logic [3:0]         pending,
  output logic [CNT_W-1:0]   cur_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [6:0]       presc_q, presc_d;
  logic [3:0]       pending_q, pending_d;

  // Per-channel view of the flat load bus.
  logic [CNT_W-1:0] load_arr [4];
  for (genvar g = 0; g < 4; g++) begin : g_load
    assign load_arr[g] = load_flat[CNT_W*g +: CNT_W];
  end

  // Index of the current owner (grant is one-hot or zero).
  logic [1:0] gidx;
  always_comb begin
    gidx = 2'd0;
    unique case (grant_q)
      4'b0010: gidx = 2'd1;
      4'b0100: gidx = 2'd2;
      4'b1000: gidx = 2'd3;
      default: gidx = 2'd0;
    endcase
  end

  // A channel being cancelled in the same cycle is not eligible.
  logic [3:0] cand;
  assign cand = pending_q & ~abort;

  // Round-robin search starting at (last+1) mod 4. The fourth probe wraps
  // back to 'last' itself, so a lone requester is always found.
  logic       pick_found;
  logic [3:0] pick_oh;
  logic [1:0] probe;
  always_comb begin
    pick_found = 1'b0;
    pick_oh    = 4'b0000;
    probe      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      probe = last_q + 2'(i);
      if (!pick_found && cand[probe]) begin
        pick_found     = 1'b1;
        pick_oh[probe] = 1'b1;
      end
    end
  end

  // Tick when the low k prescaler bits are all ones; k=0 gives an empty
  // mask and therefore a tick every cycle.
  logic [7:0] mask_w;
  logic [6:0] mask;
  logic       tick;
  assign mask_w = (8'd1 << prescaler_conf) - 8'd1;
  assign mask   = mask_w[6:0];
  assign tick   = ((presc_q & mask) == mask);

  logic abort_own;
  assign abort_own = |(abort & grant_q);

  // Outputs.
  assign done      = (state_q == S_DONE && en) ? grant_q : 4'b0000;
  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign pending   = pending_q;
  assign cur_count = count_q;

  // Pending bookkeeping: a new request beats a same-cycle clear.
  assign pending_d = (pending_q & ~(abort | done)) | req;

  // Next-state / datapath logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    presc_d = presc_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = 4'b0000;
        if (en && pick_found) begin
          grant_d = pick_oh;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!en) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
        end else if (abort_own) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          last_d  = gidx;
        end else begin
          count_d = load_arr[gidx];
          presc_d = 7'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
        end else if (abort_own) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          last_d  = gidx;
        end else begin
          presc_d = presc_q + 7'd1;
          if (tick) begin
            count_d = count_q + 1'b1;
            if (&count_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // done is only emitted while enabled; last follows the pulse.
        state_d = S_IDLE;
        grant_d = 4'b0000;
        if (en) last_d = gidx;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 4'b0000;
      last_q    <= 2'd3;
      count_q   <= '0;
      presc_q   <= 7'd0;
      pending_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      pending_q <= pending_d;
    end
  end

endmodule
